// File: rtl/device_router.sv
// Slot router: debounced module_id selects one I2C/SPI slot, switching
// only when both buses are quiet, with a deselected guard gap between slots.
module device_router #(
  parameter int NUM_MODULES     = 5,
  parameter int ID_BITS         = 3,
  parameter int SPI_BITS        = 3,
  parameter int STABLE_CYCLES   = 4,
  parameter int SPI_IDLE_CYCLES = 8,
  parameter int GUARD_CYCLES    = 3
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic [ID_BITS-1:0]              module_id,
  input  logic                            sda_oe,
  input  logic                            scl_oe,
  output logic                            sda_out,
  output logic                            scl_out,
  input  logic                            sclk,
  input  logic [NUM_MODULES*SPI_BITS-1:0] sdo_mod,
  output logic [SPI_BITS-1:0]             sdo,
  input  logic [NUM_MODULES-1:0]          mod_sda_in,
  input  logic [NUM_MODULES-1:0]          mod_scl_in,
  output logic [NUM_MODULES-1:0]          mod_sda_oe,
  output logic [NUM_MODULES-1:0]          mod_scl_oe,
  output logic [NUM_MODULES-1:0]          mod_sel,
  output logic [ID_BITS-1:0]              sel_id,
  output logic                            sel_valid,
  output logic                            busy,
  output logic                            switch_done
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int ICW = $clog2(SPI_IDLE_CYCLES + 1);
  localparam int GCW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {ACTIVE, PENDING, GUARD} state_t;

  state_t state, state_n;

  logic [ID_BITS-1:0] id_s1, id_s2, id_last, tgt_id;
  logic [SCW-1:0]     scnt;
  logic               tgt_ok, tgt_v, same;

  logic               sda_q, i2c_busy;
  logic               sclk_s1, sclk_s2, sclk_s3;
  logic [ICW-1:0]     icnt;
  logic               spi_idle;

  logic [ID_BITS-1:0] cur_id, cur_id_n;
  logic               cur_vld, cur_vld_n;
  logic [GCW-1:0]     gcnt, gcnt_n;
  logic               done_n, routed;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      id_s1   <= '0;
      id_s2   <= '0;
      id_last <= '0;
      scnt    <= '0;
      tgt_id  <= '0;
      tgt_ok  <= 1'b0;
    end else begin
      id_s1   <= module_id;
      id_s2   <= id_s1;
      id_last <= id_s2;
      if (id_s2 != id_last)
        scnt <= '0;
      else if (scnt != SCW'(STABLE_CYCLES))
        scnt <= scnt + 1'b1;
      if (id_s2 == id_last && scnt >= SCW'(STABLE_CYCLES - 1)) begin
        tgt_id <= id_s2;
        tgt_ok <= 1'b1;
      end
    end
  end

  // No accepted target yet reads as "none"
  assign tgt_v = tgt_ok && (int'(tgt_id) < NUM_MODULES);
  assign same  = tgt_v ? (cur_vld && cur_id == tgt_id) : !cur_vld;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sda_q    <= 1'b0;
      i2c_busy <= 1'b0;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      icnt     <= '0;
    end else begin
      sda_q <= sda_oe;
      if (!scl_oe && sda_oe && !sda_q)
        i2c_busy <= 1'b1;
      else if (!scl_oe && !sda_oe && sda_q)
        i2c_busy <= 1'b0;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      if (sclk_s2 != sclk_s3)
        icnt <= '0;
      else if (icnt != ICW'(SPI_IDLE_CYCLES))
        icnt <= icnt + 1'b1;
    end
  end

  assign spi_idle = icnt >= ICW'(SPI_IDLE_CYCLES);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= PENDING;
      cur_id      <= '0;
      cur_vld     <= 1'b0;
      gcnt        <= '0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_n;
      cur_id      <= cur_id_n;
      cur_vld     <= cur_vld_n;
      gcnt        <= gcnt_n;
      switch_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_id_n  = cur_id;
    cur_vld_n = cur_vld;
    gcnt_n    = gcnt;
    done_n    = 1'b0;
    case (state)
      ACTIVE: begin
        if (!same)
          state_n = PENDING;
      end
      PENDING: begin
        if (same) begin
          state_n = ACTIVE;
        end else if (!i2c_busy && spi_idle) begin
          state_n = GUARD;
          gcnt_n  = '0;
        end
      end
      GUARD: begin
        // Load whatever target is stable at the end of the gap
        if (gcnt == GCW'(GUARD_CYCLES - 1)) begin
          state_n   = ACTIVE;
          cur_vld_n = tgt_v;
          cur_id_n  = tgt_v ? tgt_id : '0;
          done_n    = 1'b1;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = PENDING;
    endcase
  end

  assign busy   = state != ACTIVE;
  assign routed = cur_vld && state != GUARD;

  always_comb begin
    mod_sel    = '0;
    mod_sda_oe = '0;
    mod_scl_oe = '0;
    sda_out    = 1'b1;
    scl_out    = 1'b1;
    sdo        = '1;
    sel_id     = '0;
    sel_valid  = 1'b0;
    if (routed) begin
      sel_valid = 1'b1;
      sel_id    = cur_id;
      for (int i = 0; i < NUM_MODULES; i++) begin
        if (cur_id == ID_BITS'(i)) begin
          mod_sel[i]    = 1'b1;
          mod_sda_oe[i] = sda_oe;
          mod_scl_oe[i] = scl_oe;
          sda_out       = mod_sda_in[i];
          scl_out       = mod_scl_in[i];
          sdo           = sdo_mod[i*SPI_BITS +: SPI_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_device_router.sv
// Directed bench for device_router: reset, slot switching under
// I2C/SPI activity, glitch rejection, "none" target, reset mid-guard.
module tb_device_router;

  logic        clk = 1'b0;
  logic        nreset;
  logic [2:0]  module_id;
  logic        sda_oe, scl_oe, sda_out, scl_out, sclk;
  logic [14:0] sdo_mod;
  logic [2:0]  sdo;
  logic [4:0]  mod_sda_in, mod_scl_in;
  logic [4:0]  mod_sda_oe, mod_scl_oe, mod_sel;
  logic [2:0]  sel_id;
  logic        sel_valid, busy, switch_done;

  int checks = 0;
  int errors = 0;
  int first0, nzero, ndone, bad;

  device_router dut (
    .clk(clk), .nreset(nreset), .module_id(module_id),
    .sda_oe(sda_oe), .scl_oe(scl_oe),
    .sda_out(sda_out), .scl_out(scl_out),
    .sclk(sclk), .sdo_mod(sdo_mod), .sdo(sdo),
    .mod_sda_in(mod_sda_in), .mod_scl_in(mod_scl_in),
    .mod_sda_oe(mod_sda_oe), .mod_scl_oe(mod_scl_oe),
    .mod_sel(mod_sel), .sel_id(sel_id), .sel_valid(sel_valid),
    .busy(busy), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run until a switch_done pulse (or bound), noting deselected cycles
  task automatic wait_sw(input int bound, output int f0, output int nz,
                         output int nd);
    f0 = -1;
    nz = 0;
    nd = 0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (mod_sel == 5'b0) begin
        if (f0 < 0) f0 = i;
        nz++;
      end
      if (switch_done) begin
        nd++;
        break;
      end
    end
  endtask

  task automatic deselected(input string tag);
    check({tag, "_sel"}, mod_sel, 5'b0);
    check({tag, "_vld"}, sel_valid, 1'b0);
    check({tag, "_id"}, sel_id, 3'd0);
    check({tag, "_sdo"}, sdo, 3'b111);
    check({tag, "_sda"}, sda_out, 1'b1);
    check({tag, "_scl"}, scl_out, 1'b1);
    check({tag, "_oe"}, {mod_sda_oe, mod_scl_oe}, 10'b0);
  endtask

  initial begin
    nreset     = 1'b0;
    module_id  = 3'd2;
    sda_oe     = 1'b0;
    scl_oe     = 1'b0;
    sclk       = 1'b0;
    sdo_mod    = {3'b011, 3'b110, 3'b101, 3'b010, 3'b001};
    mod_sda_in = 5'b11011;
    mod_scl_in = 5'b00100;
    tick(3);
    deselected("rst");
    check("rst_busy", busy, 1'b1);
    check("rst_done", switch_done, 1'b0);

    // Slot 2 after reset
    nreset = 1'b1;
    wait_sw(100, first0, nzero, ndone);
    check("s2_done", ndone, 1);
    check("s2_sel", mod_sel, 5'b00100);
    check("s2_vld", sel_valid, 1'b1);
    check("s2_id", sel_id, 3'd2);
    check("s2_sdo", sdo, 3'b101);
    check("s2_sda", sda_out, 1'b0);
    check("s2_scl", scl_out, 1'b1);
    tick();
    check("s2_pulse", switch_done, 1'b0);
    check("s2_busy", busy, 1'b0);
    scl_oe = 1'b1;
    tick();
    sda_oe = 1'b1;
    #1;
    check("s2_sda_oe", mod_sda_oe, 5'b00100);
    check("s2_scl_oe", mod_scl_oe, 5'b00100);
    tick();
    sda_oe = 1'b0;
    tick();
    scl_oe = 1'b0;
    tick();

    // START holds slot 2 until STOP
    sda_oe = 1'b1;
    tick();
    module_id = 3'd4;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mod_sel != 5'b00100 || !busy && i > 10) bad++;
    end
    check("i2c_hold", bad, 0);
    check("i2c_busy", busy, 1'b1);
    check("i2c_oe", mod_sda_oe, 5'b00100);
    sda_oe = 1'b0;
    wait_sw(100, first0, nzero, ndone);
    check("s4_done", ndone, 1);
    check("s4_first0", first0, 2);
    check("s4_guard", nzero, 3);
    check("s4_sel", mod_sel, 5'b10000);
    check("s4_sdo", sdo, 3'b011);

    // SPI activity delays the switch
    module_id = 3'd1;
    wait_sw(100, first0, nzero, ndone);
    check("s1_done", ndone, 1);
    check("s1_sel", mod_sel, 5'b00010);
    module_id = 3'd3;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      tick();
      if (mod_sel != 5'b00010) bad++;
    end
    check("spi_hold", bad, 0);
    check("spi_busy", busy, 1'b1);
    wait_sw(100, first0, nzero, ndone);
    check("s3_done", ndone, 1);
    check("s3_first0", first0, 11);
    check("s3_guard", nzero, 3);
    check("s3_sel", mod_sel, 5'b01000);
    check("s3_sdo", sdo, 3'b110);

    // Short glitch ignored
    module_id = 3'd0;
    wait_sw(100, first0, nzero, ndone);
    check("s0_sel", mod_sel, 5'b00001);
    tick(2);
    module_id = 3'd3;
    tick(2);
    module_id = 3'd0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy || switch_done || mod_sel != 5'b00001) bad++;
    end
    check("glitch", bad, 0);

    // Out-of-range id routes nothing
    module_id = 3'd7;
    wait_sw(100, first0, nzero, ndone);
    check("none_done", ndone, 1);
    deselected("none");
    check("none_busy", busy, 1'b0);
    scl_oe = 1'b1;
    #1;
    check("none_scl_oe", mod_scl_oe, 5'b0);
    scl_oe = 1'b0;

    // Reset during guard
    module_id = 3'd1;
    wait_sw(100, first0, nzero, ndone);
    check("r1_sel", mod_sel, 5'b00010);
    module_id = 3'd2;
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mod_sel == 5'b0) begin
        bad = 0;
        break;
      end
    end
    check("guard_seen", bad, 0);
    tick();
    #1;
    nreset = 1'b0;
    #1;
    deselected("rg");
    check("rg_busy", busy, 1'b1);
    check("rg_done", switch_done, 1'b0);
    tick(2);
    nreset = 1'b1;
    wait_sw(100, first0, nzero, ndone);
    check("rg_done2", ndone, 1);
    check("rg_sel", mod_sel, 5'b00100);

    // Reset mid-transfer deselects at once
    scl_oe = 1'b1;
    sda_oe = 1'b1;
    tick();
    check("mt_oe", mod_sda_oe, 5'b00100);
    #1;
    nreset = 1'b0;
    #1;
    deselected("mt");
    check("mt_busy", busy, 1'b1);
    tick(2);
    nreset = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
